lc4_stall_profiler: RTL

LC4_STALL_PROFILER -- requirements
Module: lc4_stall_profiler

---
 rtl/lc4_stall_profiler_pkg.sv | 32 +++
 rtl/lc4_sat_counter.sv | 47 ++++
 rtl/lc4_stall_profiler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lc4_stall_profiler_pkg.sv
// Shared encodings for the LC4 stall profiler: stall codes, read selects and
// snapshot FSM states.
package lc4_stall_profiler_pkg;

    typedef enum logic [1:0] {
        STALL_EXEC   = 2'd0,
        STALL_CACHE  = 2'd1,
        STALL_BRANCH = 2'd2,
        STALL_LOAD   = 2'd3
    } stall_code_e;

    typedef enum logic [2:0] {
        SEL_CYCLES = 3'd0,
        SEL_EXEC   = 3'd1,
        SEL_CACHE  = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_LOAD   = 3'd4
    } rd_sel_e;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_e;

    localparam int unsigned NUM_CNT = 5;

    // Category counters sit directly after the cycle counter, in stall-code order.
    function automatic logic [2:0] cnt_idx(input stall_code_e code);
        return 3'(code) + 3'd1;
    endfunction

endpackage

// File: rtl/lc4_sat_counter.sv
// Event counter with wrap or saturate behaviour and a sticky overflow flag.
// `value` is the count including this cycle's increment, before any clear.
module lc4_sat_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    always_comb begin
        at_max = &value_q;
        value  = value_q;
        ovf_d  = ovf_q;
        if (inc) begin
            if (at_max) begin
                ovf_d = 1'b1;
                if (SAT_MODE == 0) value = '0;
            end else begin
                value = value_q + WIDTH'(1);
            end
        end
        value_d = clr ? '0 : value;
        if (clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: rtl/lc4_stall_profiler.sv
// Per-channel pipeline stall profiler: live cycle/category counters, a
// request/acknowledge snapshot shadow bank and a registered read port.
module lc4_stall_profiler
    import lc4_stall_profiler_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gwe,
    input  logic                en,
    input  logic [NUM_CH-1:0]   ch_valid,
    input  logic [2*NUM_CH-1:0] ch_stall,
    input  logic                clear,
    input  logic                snap_req,
    input  logic                snap_ack,
    output logic                snap_valid,
    input  logic [1:0]          rd_ch,
    input  logic [2:0]          rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic [NUM_CH-1:0]   ovf
);

    snap_state_e state_q, state_d;
    logic        capture;

    logic [NUM_CH*NUM_CNT*CNT_W-1:0] live_flat;
    logic [CNT_W-1:0] shadow_q [NUM_CH][NUM_CNT];
    logic [CNT_W-1:0] shadow_d [NUM_CH][NUM_CNT];
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic               qual;
        stall_code_e        code;
        logic [NUM_CNT-1:0] inc;
        logic [NUM_CNT-1:0] cnt_ovf;

        always_comb begin
            qual = gwe & en & ch_valid[c];
            code = stall_code_e'(ch_stall[2*c +: 2]);
            inc  = '0;
            if (qual) begin
                inc[SEL_CYCLES]    = 1'b1;
                inc[cnt_idx(code)] = 1'b1;
            end
        end

        for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
            lc4_sat_counter #(
                .WIDTH    (CNT_W),
                .SAT_MODE (SAT_MODE)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc[k]),
                .clr   (clear),
                .value (live_flat[(c*NUM_CNT + k)*CNT_W +: CNT_W]),
                .ovf   (cnt_ovf[k])
            );
        end

        assign ovf[c] = |cnt_ovf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SNAP_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SNAP_IDLE: if (snap_req) state_d = SNAP_HOLD;
            SNAP_HOLD: if (snap_ack) state_d = SNAP_IDLE;
            default:   state_d = SNAP_IDLE;
        endcase
    end

    always_comb begin
        capture    = (state_q == SNAP_IDLE) & snap_req;
        snap_valid = (state_q == SNAP_HOLD);
    end

    // Capture taps the pre-clear incremented value, so clear+snap_req in one
    // cycle still freezes the counts that clear is about to discard.
    always_comb begin
        shadow_d = shadow_q;
        if (capture) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned k = 0; k < NUM_CNT; k++) begin
                    shadow_d[c][k] = live_flat[(c*NUM_CNT + k)*CNT_W +: CNT_W];
                end
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                if (rd_ch == 2'(c) && rd_sel == 3'(k)) rd_data_d = shadow_q[c][k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned k = 0; k < NUM_CNT; k++) begin
                    shadow_q[c][k] <= '0;
                end
            end
            rd_data_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
